// File: rtl/spi_master_packet_pkg.sv
// Shared SPI definitions: frame geometry defaults and the master FSM state type.
// The frame-size constants are also used by the slave-side design.
package spi_pkg;
    localparam int SPI_PACKET_SIZE = 8;
    localparam int SPI_BYTE_SIZE   = 8;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        XFER,
        TRAIL,
        GAP
    } spi_state_t;

    function automatic int spi_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/spi_master_packet_if.sv
// Parallel handshake plus SPI wire bundle for the packet SPI master.
// The master modport is the DUT side; slave is the host/pin side.
interface spi_master_packet_if
    import spi_pkg::*;
#(
    parameter int N = SPI_PACKET_SIZE * SPI_BYTE_SIZE
);
    logic         startIn;
    logic [N-1:0] dataIn;
    logic         misoIn;
    logic         ssOut;
    logic         sckOut;
    logic         mosiOut;
    logic [N-1:0] dataOut;
    logic         doneOut;
    logic         busyOut;

    modport master (
        input  startIn, dataIn, misoIn,
        output ssOut, sckOut, mosiOut, dataOut, doneOut, busyOut
    );

    modport slave (
        output startIn, dataIn, misoIn,
        input  ssOut, sckOut, mosiOut, dataOut, doneOut, busyOut
    );
endinterface

// File: rtl/spi_master_packet_sck_divider.sv
// SCK generator: CLK_DIV clk cycles per half-period, low phase first.
// Strobes are high in the cycle whose closing edge changes SCK.
module spi_sck_divider #(
    parameter int CLK_DIV = 8
) (
    input  logic clk,
    input  logic nResetIn,
    input  logic i_en,
    output logic o_sck,
    output logic o_rise,
    output logic o_fall
);
    localparam int            HW        = $clog2(CLK_DIV + 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);

    logic [HW-1:0] r_half;
    logic          r_sck;
    logic          w_wrap;

    assign w_wrap = i_en && (r_half == HALF_LAST);
    assign o_rise = w_wrap && !r_sck;
    assign o_fall = w_wrap && r_sck;
    assign o_sck  = r_sck;

    // Disabled means parked: counter and SCK return to zero so each frame starts on a fresh low phase.
    always_ff @(posedge clk or negedge nResetIn) begin
        if (!nResetIn) begin
            r_half <= '0;
            r_sck  <= 1'b0;
        end else if (!i_en) begin
            r_half <= '0;
            r_sck  <= 1'b0;
        end else if (w_wrap) begin
            r_half <= '0;
            r_sck  <= ~r_sck;
        end else begin
            r_half <= r_half + 1'b1;
        end
    end
endmodule

// File: rtl/spi_master_packet.sv
// Mode-0 packet SPI master: one N-bit frame out on MOSI while capturing MISO,
// with SS guard times and an inter-frame gap sized for the slave's input filters.
module spi_master_packet
    import spi_pkg::*;
#(
    parameter int PACKET_SIZE = SPI_PACKET_SIZE,
    parameter int BYTE_SIZE   = SPI_BYTE_SIZE,
    parameter int CLK_DIV     = 8,
    parameter int SS_GUARD    = 4,
    parameter int GAP_CYCLES  = 8
) (
    input logic                 clk,
    input logic                 nResetIn,
    spi_master_packet_if.master bus
);
    localparam int N    = PACKET_SIZE * BYTE_SIZE;
    localparam int BW   = $clog2(N + 1);
    localparam int CMAX = spi_max(SS_GUARD, GAP_CYCLES);
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [BW-1:0] BIT_LAST   = BW'(N - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'(SS_GUARD - 1);
    localparam logic [CW-1:0] GAP_LAST   = (GAP_CYCLES == 0) ? '0 : CW'(GAP_CYCLES - 1);

    spi_state_t    r_state;
    logic [N-2:0]  r_tx;      // bits still to send after the one on MOSI
    logic [N-1:0]  r_rx;
    logic [N-1:0]  r_data;
    logic [BW-1:0] r_bit;
    logic [CW-1:0] r_cnt;     // shared by LEAD, TRAIL and GAP
    logic          r_ss;
    logic          r_mosi;
    logic          r_done;
    logic          r_busy;

    logic w_en;
    logic w_sck;
    logic w_rise;
    logic w_fall;

    assign w_en = (r_state == XFER);

    spi_sck_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk      (clk),
        .nResetIn (nResetIn),
        .i_en     (w_en),
        .o_sck    (w_sck),
        .o_rise   (w_rise),
        .o_fall   (w_fall)
    );

    always_ff @(posedge clk or negedge nResetIn) begin
        if (!nResetIn) begin
            r_state <= IDLE;
            r_tx    <= '0;
            r_rx    <= '0;
            r_data  <= '0;
            r_bit   <= '0;
            r_cnt   <= '0;
            r_ss    <= 1'b1;
            r_mosi  <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.startIn) begin
                        r_tx    <= bus.dataIn[N-2:0];
                        r_mosi  <= bus.dataIn[N-1];
                        r_ss    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_bit   <= '0;
                        r_cnt   <= '0;
                        r_state <= LEAD;
                    end
                end
                LEAD: begin
                    if (r_cnt == GUARD_LAST) begin
                        r_cnt   <= '0;
                        r_state <= XFER;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                XFER: begin
                    if (w_rise) r_rx <= {r_rx[N-2:0], bus.misoIn};
                    // Last falling edge leaves MOSI on the final bit through TRAIL.
                    if (w_fall) begin
                        r_bit <= r_bit + 1'b1;
                        if (r_bit == BIT_LAST) begin
                            r_state <= TRAIL;
                        end else begin
                            r_mosi <= r_tx[N-2];
                            r_tx   <= {r_tx[N-3:0], 1'b0};
                        end
                    end
                end
                TRAIL: begin
                    if (r_cnt == GUARD_LAST) begin
                        r_cnt  <= '0;
                        r_ss   <= 1'b1;
                        r_data <= r_rx;
                        r_done <= 1'b1;
                        if (GAP_CYCLES == 0) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= GAP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.ssOut   = r_ss;
    assign bus.sckOut  = w_sck;
    assign bus.mosiOut = r_mosi;
    assign bus.dataOut = r_data;
    assign bus.doneOut = r_done;
    assign bus.busyOut = r_busy;
endmodule

// File: doc/spi_master_packet.md
Name: spi_master_packet

Overview:
- Packet-oriented SPI master (mode 0) that drives the filter board's SPI slave port from a host-side/test FPGA.
- Shifts one PACKET_SIZE-byte frame out on MOSI while capturing the simultaneous MISO frame.
- Uses a start/done handshake on the parallel side.
- Guarantees slow enough SCK and guard times for the slave's 3-sample majority input filters.

Parameters:
- PACKET_SIZE, 8, bytes per frame.
- BYTE_SIZE, 8, bits per byte.
- CLK_DIV, 8, clk cycles per SCK half-period; must be >= 1.
- SS_GUARD, 4, clk cycles with SS low before the first SCK edge and after the last SCK edge; must be >= 1.
- GAP_CYCLES, 8, minimum clk cycles SS stays high between frames; 0 allowed.

Ports:
- clk  in  1  system clock.
- nResetIn  in  1  asynchronous, active-low reset.
- startIn  in  1  request a frame; sampled only in IDLE.
- dataIn  in  PACKET_SIZE*BYTE_SIZE  TX frame; MSB is the first bit on the wire; latched on accepted start.
- misoIn  in  1  serial data from the slave.
- ssOut  out  1  slave select, active low.
- sckOut  out  1  SPI clock, idle low.
- mosiOut  out  1  serial data to the slave.
- dataOut  out  PACKET_SIZE*BYTE_SIZE  RX frame; first received bit lands in the MSB.
- doneOut  out  1  one-cycle pulse when the frame is complete.
- busyOut  out  1  high from start acceptance until return to IDLE.

Behaviour:
- Definitions: N = PACKET_SIZE*BYTE_SIZE; L = 2*SS_GUARD + 2*CLK_DIV*N.
- Reset: applies asynchronously, immediately, including mid-frame. Reset values: ssOut=1, sckOut=0, mosiOut=0, doneOut=0, busyOut=0, dataOut=0, state=IDLE, all counters 0. No partial dataOut update.
- States: IDLE, LEAD, XFER, TRAIL, GAP.
- IDLE: startIn=1 at edge T latches dataIn into the TX shift register. From cycle T+1: state LEAD, ssOut=0, busyOut=1, mosiOut=dataIn[N-1].
- LEAD: lasts SS_GUARD cycles with sckOut=0, then goes to XFER.
- XFER, per bit: sckOut low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - On the clk edge that drives sckOut 0->1, misoIn is shifted into the RX register LSB (sampling the pre-rise value).
  - On the edge that drives sckOut 1->0, the TX register shifts and mosiOut presents the next bit. For the final bit mosiOut holds its value.
  - After the N-th high phase, sckOut=0 and state goes to TRAIL.
- TRAIL: lasts SS_GUARD cycles with sckOut=0, mosiOut held.
- End of TRAIL (one edge):
  - ssOut=1.
  - dataOut <= RX register.
  - doneOut=1 for exactly one cycle.
  - State goes to GAP (or IDLE directly if GAP_CYCLES=0).
- ssOut is low for exactly L cycles. Exactly N rising SCK edges occur per frame.
- GAP: lasts GAP_CYCLES cycles with ssOut=1, then IDLE; busyOut drops on entry to IDLE.
- Start-to-done latency: doneOut is high in cycle T+1+L.
- Start rules:
  - startIn while busyOut=1 is ignored; no queuing.
  - startIn held high is re-accepted on the first IDLE cycle, so back-to-back frames are separated by GAP_CYCLES+1 ssOut-high cycles.
- dataOut holds its value until the next doneOut. dataIn may change freely after acceptance.
- Counters:
  - Bit counter width $clog2(N+1); half-period counter width $clog2(CLK_DIV+1).
  - No wrap-around beyond N; the bit counter terminates at N.
- misoIn is not synchronised here; callers insert a synchroniser if the slave is asynchronous.

Decomposition:
- Shared package spi_pkg:
  - spi_state_t enum {IDLE, LEAD, XFER, TRAIL, GAP}.
  - Default PACKET_SIZE/BYTE_SIZE constants, shared with the slave side.
- One sub-module, spi_sck_divider:
  - Half-period counter generating registered sckOut plus one-cycle rise/fall strobes.
  - Enabled only in XFER.
  - The parent handles shifting and the FSM.

Test Plan:
1. Loopback (misoIn=mosiOut, defaults), dataIn=64'h0123_4567_89AB_CDEF, startIn pulse at T -> dataOut=64'h0123_4567_89AB_CDEF; doneOut single pulse at T+1+1032; exactly 64 sckOut rises; ssOut low for 1032 cycles.
2. misoIn tied 0 then tied 1, dataIn=64'hA5A5_A5A5_A5A5_A5A5 -> dataOut=0 then 64'hFFFF_FFFF_FFFF_FFFF; MOSI bit stream checked MSB-first against the pattern on every sckOut rise.
3. Second startIn pulse mid-XFER with different dataIn -> ignored; one doneOut only; first frame data unchanged.
4. startIn held high for 3 frames -> three doneOut pulses spaced 1032+9 cycles; ssOut high exactly 9 cycles between frames.
5. nResetIn low during bit 20 of XFER -> same cycle ssOut=1, sckOut=0, busyOut=0, dataOut=0; after release a new frame completes correctly.
6. CLK_DIV=1, SS_GUARD=1, GAP_CYCLES=0, PACKET_SIZE=1, loopback 8'h3C -> dataOut=8'h3C; doneOut at T+1+18; sckOut toggles every cycle during XFER.
